// File: rtl/line_prefetch_buffer.sv
// One-entry next-line prefetch buffer between L2 and downstream memory.
// Every L2 read is followed by a fetch of the sequentially next line into the buffer.
module line_prefetch_buffer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pfb_mem_read,
    input  logic                  pfb_mem_write,
    input  logic [ADDR_WIDTH-1:0] pfb_mem_address,
    input  logic [LINE_WIDTH-1:0] pfb_mem_wdata,
    output logic [LINE_WIDTH-1:0] pfb_mem_rdata,
    output logic                  pfb_mem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, DEMAND_READ, PREFETCH, WRITE} state_t;

    state_t                 state, state_next;
    logic                   buf_valid;
    logic [TAG_WIDTH-1:0]   buf_tag;
    logic [LINE_WIDTH-1:0]  buf_data;
    logic [TAG_WIDTH-1:0]   pf_tag;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   hit;

    assign req_tag = pfb_mem_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign hit     = buf_valid && (buf_tag == req_tag);

    always_comb begin
        state_next    = state;
        pfb_mem_resp  = 1'b0;
        pfb_mem_rdata = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                // Writes win if L2 ever raises both strobes.
                if (pfb_mem_write) begin
                    state_next = WRITE;
                end else if (pfb_mem_read) begin
                    if (hit) begin
                        pfb_mem_resp  = 1'b1;
                        pfb_mem_rdata = buf_data;
                        state_next    = PREFETCH;
                    end else begin
                        state_next = DEMAND_READ;
                    end
                end
            end
            DEMAND_READ: begin
                mem_read    = 1'b1;
                mem_address = pfb_mem_address;
                if (mem_resp) begin
                    pfb_mem_resp  = 1'b1;
                    pfb_mem_rdata = mem_rdata;
                    state_next    = PREFETCH;
                end
            end
            PREFETCH: begin
                mem_read    = 1'b1;
                mem_address = {pf_tag, {OFFSET_BITS{1'b0}}};
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                mem_write   = 1'b1;
                mem_address = pfb_mem_address;
                mem_wdata   = pfb_mem_wdata;
                if (mem_resp) begin
                    pfb_mem_resp = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            pf_tag    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (!pfb_mem_write && pfb_mem_read && hit) begin
                        buf_valid <= 1'b0;
                        pf_tag    <= req_tag + TAG_WIDTH'(1);
                    end
                end
                DEMAND_READ: begin
                    if (mem_resp) begin
                        pf_tag <= req_tag + TAG_WIDTH'(1);
                    end
                end
                PREFETCH: begin
                    if (mem_resp) begin
                        buf_valid <= 1'b1;
                        buf_tag   <= pf_tag;
                        buf_data  <= mem_rdata;
                    end
                end
                WRITE: begin
                    // Keep the buffered copy coherent with the line just written.
                    if (mem_resp && hit) begin
                        buf_data <= pfb_mem_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
